// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter
//   Two-master, one-slave memory bus arbiter. m0 is the data port, m1 the
//   fetch/DMA port. Ties are broken round-robin against the last grant, so two
//   masters that keep requesting alternate strictly. The granted master's
//   request is captured on grant entry, and the bus is driven only from that
//   capture. A grant ends on bus_ready, or with an error pulse once the wait
//   counter reaches TIMEOUT.
//
// Ports
//   clock, reset                     rising-edge clock, async active-high reset
//   m{0,1}_req                       transaction request, held until done
//   m{0,1}_address/_write_data       byte address / store data
//   m{0,1}_byte_enable               byte lanes
//   m{0,1}_write_enable              1 = write, 0 = read
//   m{0,1}_done/_error               one-cycle completion / timeout pulses
//   m{0,1}_read_data                 read result, valid with done
//   bus_address/_write_data/_byte_enable, bus_read_enable, bus_write_enable
//   bus_read_data, bus_ready         slave return data / completion
//
// state  | meaning
// IDLE   | no owner; arbitrate pending requests
// GRANT0 | m0 owns the bus; waiting for bus_ready or timeout
// GRANT1 | m1 owns the bus; waiting for bus_ready or timeout
module memory_bus_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_write_data,
  input  logic [3:0]  m0_byte_enable,
  input  logic        m0_write_enable,
  output logic        m0_done,
  output logic        m0_error,
  output logic [31:0] m0_read_data,
  input  logic        m1_req,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_write_data,
  input  logic [3:0]  m1_byte_enable,
  input  logic        m1_write_enable,
  output logic        m1_done,
  output logic        m1_error,
  output logic [31:0] m1_read_data,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  output logic        bus_read_enable,
  output logic        bus_write_enable,
  input  logic [31:0] bus_read_data,
  input  logic        bus_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] lat_address_q, lat_write_data_q;
  logic [3:0]  lat_byte_enable_q;
  logic        lat_write_enable_q;

  logic        load_en;
  logic        load_sel;

  logic        txn_done;
  logic        txn_error;
  logic [31:0] txn_read_data;
  logic        owner;

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    wait_cnt_d       = wait_cnt_q;
    load_en          = 1'b0;
    load_sel         = 1'b0;
    txn_done         = 1'b0;
    txn_error        = 1'b0;
    txn_read_data    = 32'd0;
    owner            = 1'b0;
    bus_address      = 32'd0;
    bus_write_data   = 32'd0;
    bus_byte_enable  = 4'd0;
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;

    case (state_q)
      IDLE: begin
        wait_cnt_d = 8'd0;
        // m0 wins when alone, or on a tie when m1 held the bus last.
        if (m0_req && (!m1_req || last_grant_q)) begin
          state_d  = GRANT0;
          load_en  = 1'b1;
          load_sel = 1'b0;
        end else if (m1_req) begin
          state_d  = GRANT1;
          load_en  = 1'b1;
          load_sel = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        owner            = (state_q == GRANT1);
        bus_address      = lat_address_q;
        bus_write_data   = lat_write_data_q;
        bus_byte_enable  = lat_byte_enable_q;
        bus_write_enable = lat_write_enable_q;
        bus_read_enable  = ~lat_write_enable_q;
        if (bus_ready) begin
          txn_done      = 1'b1;
          txn_read_data = bus_read_data;
          state_d       = IDLE;
          last_grant_d  = owner;
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          txn_done     = 1'b1;
          txn_error    = 1'b1;
          state_d      = IDLE;
          last_grant_d = owner;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    m0_done      = txn_done  & ~owner;
    m0_error     = txn_error & ~owner;
    m0_read_data = owner ? 32'd0 : txn_read_data;
    m1_done      = txn_done  & owner;
    m1_error     = txn_error & owner;
    m1_read_data = owner ? txn_read_data : 32'd0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      wait_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_address_q      <= 32'd0;
      lat_write_data_q   <= 32'd0;
      lat_byte_enable_q  <= 4'd0;
      lat_write_enable_q <= 1'b0;
    end else if (load_en) begin
      lat_address_q      <= load_sel ? m1_address      : m0_address;
      lat_write_data_q   <= load_sel ? m1_write_data   : m0_write_data;
      lat_byte_enable_q  <= load_sel ? m1_byte_enable  : m0_byte_enable;
      lat_write_enable_q <= load_sel ? m1_write_enable : m0_write_enable;
    end
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
module tb_memory_bus_arbiter;

  localparam int TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_req, m1_req;
  logic [31:0] m0_address, m1_address, m0_write_data, m1_write_data;
  logic [3:0]  m0_byte_enable, m1_byte_enable;
  logic        m0_write_enable, m1_write_enable;
  logic        m0_done, m1_done, m0_error, m1_error;
  logic [31:0] m0_read_data, m1_read_data;
  logic [31:0] bus_address, bus_write_data, bus_read_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_enable, bus_write_enable, bus_ready;

  int checks = 0;
  int errors = 0;

  memory_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_address(m0_address), .m0_write_data(m0_write_data),
    .m0_byte_enable(m0_byte_enable), .m0_write_enable(m0_write_enable),
    .m0_done(m0_done), .m0_error(m0_error), .m0_read_data(m0_read_data),
    .m1_req(m1_req), .m1_address(m1_address), .m1_write_data(m1_write_data),
    .m1_byte_enable(m1_byte_enable), .m1_write_enable(m1_write_enable),
    .m1_done(m1_done), .m1_error(m1_error), .m1_read_data(m1_read_data),
    .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_byte_enable(bus_byte_enable), .bus_read_enable(bus_read_enable),
    .bus_write_enable(bus_write_enable), .bus_read_data(bus_read_data),
    .bus_ready(bus_ready)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    m0_req = 0; m1_req = 0;
    m0_address = 0; m1_address = 0; m0_write_data = 0; m1_write_data = 0;
    m0_byte_enable = 0; m1_byte_enable = 0; m0_write_enable = 0; m1_write_enable = 0;
    bus_read_data = 0; bus_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1;
    drive_idle();
    @(negedge clock);
    reset = 0;
  endtask

  task automatic test_reset();
    logic [169:0] outs;
    @(negedge clock);
    reset = 1;
    m0_req = 1; m1_req = 1; bus_ready = 1; bus_read_data = $urandom;
    m0_address = $urandom; m1_address = $urandom; m0_write_enable = 1;
    #1;
    outs = {bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable,
            m0_done, m1_done, m0_error, m1_error, m0_read_data, m1_read_data};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    @(negedge clock);
    #1;
    outs = {bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable,
            m0_done, m1_done, m0_error, m1_error, m0_read_data, m1_read_data};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_held: got %h expected 0", outs);
    end
    drive_idle();
    reset = 0;
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req = 1; m0_address = 32'h100; m0_write_enable = 0; m0_byte_enable = 4'hF;
    @(negedge clock);
    bus_ready = 1; bus_read_data = 32'hDEADBEEF;
    #1;
    checks++;
    if ({bus_read_enable, bus_write_enable, bus_address} !== {1'b1, 1'b0, 32'h100}) begin
      errors++;
      $display("FAIL single_read_bus: got re=%b we=%b addr=%h expected re=1 we=0 addr=00000100",
               bus_read_enable, bus_write_enable, bus_address);
    end
    checks++;
    if ({m0_done, m0_error, m0_read_data, m1_done} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL single_read_done: got done=%b err=%b rd=%h m1_done=%b expected 1 0 deadbeef 0",
               m0_done, m0_error, m0_read_data, m1_done);
    end
    m0_req = 0;
    @(negedge clock);
    #1;
    checks++;
    if ({bus_read_enable, m0_done} !== 2'b00) begin
      errors++;
      $display("FAIL single_read_after: got re=%b done=%b expected 0 0", bus_read_enable, m0_done);
    end
  endtask

  task automatic test_alternate();
    logic [2:0] got, exp;
    do_reset();
    m0_req = 1; m1_req = 1; bus_ready = 1; bus_read_data = $urandom;
    m0_address = 32'hA0; m1_address = 32'hB0;
    #1;
    checks++;
    if ({m0_done, m1_done, bus_read_enable} !== 3'b000) begin
      errors++;
      $display("FAIL alt_first_idle: got %b expected 000", {m0_done, m1_done, bus_read_enable});
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      #1;
      got = {m0_done, m1_done, bus_read_enable};
      if (k % 2 == 1) exp = 3'b000;
      else if ((k / 2) % 2 == 0) exp = 3'b101;
      else exp = 3'b011;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL alternate[%0d]: got %b expected %b", k, got, exp);
      end
    end
    m0_req = 0; m1_req = 0;
  endtask

  task automatic test_write_hold();
    do_reset();
    m1_req = 1; m1_address = 32'h200; m1_write_data = 32'h12345678;
    m1_byte_enable = 4'b0011; m1_write_enable = 1; bus_ready = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      if (c == 2) m1_address = 32'h300;
      if (c == 4) bus_ready = 1;
      #1;
      checks++;
      if ({bus_address, bus_write_data, bus_byte_enable, bus_write_enable, bus_read_enable}
          !== {32'h200, 32'h12345678, 4'b0011, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL write_hold_bus[%0d]: got addr=%h wd=%h be=%b we=%b re=%b expected 00000200 12345678 0011 1 0",
                 c, bus_address, bus_write_data, bus_byte_enable, bus_write_enable, bus_read_enable);
      end
      checks++;
      if ({m1_done, m1_error, m0_done} !== {(c == 4), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL write_hold_done[%0d]: got m1_done=%b m1_err=%b m0_done=%b expected %b 0 0",
                 c, m1_done, m1_error, m0_done, (c == 4));
      end
    end
    m1_req = 0;
    @(negedge clock);
    #1;
    checks++;
    if (bus_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL write_hold_after: got we=%b expected 0", bus_write_enable);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    m0_req = 1; m0_address = $urandom; m0_write_enable = 0; bus_ready = 0;
    bus_read_data = $urandom | 32'h1;
    for (int c = 1; c <= TIMEOUT + 1; c++) begin
      @(negedge clock);
      #1;
      checks++;
      if ({bus_read_enable, m0_done, m0_error, m0_read_data, m1_done}
          !== {1'b1, (c == TIMEOUT + 1), (c == TIMEOUT + 1), 32'd0, 1'b0}) begin
        errors++;
        $display("FAIL timeout[%0d]: got re=%b done=%b err=%b rd=%h m1_done=%b expected 1 %b %b 0 0",
                 c, bus_read_enable, m0_done, m0_error, m0_read_data, m1_done,
                 (c == TIMEOUT + 1), (c == TIMEOUT + 1));
      end
    end
    m0_req = 0;
    @(negedge clock);
    #1;
    checks++;
    if ({bus_read_enable, m0_done, m0_error} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_idle: got %b expected 000", {bus_read_enable, m0_done, m0_error});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_req = 1; m0_address = 32'h40; m0_write_enable = 0; bus_ready = 0;
    bus_read_data = 32'h5A5A1234;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clock);
      #1;
      checks++;
      if (bus_read_enable !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_wait[%0d]: got re=%b expected 1", c, bus_read_enable);
      end
    end
    #1;
    reset = 1;
    #1;
    checks++;
    if ({bus_read_enable, m0_done, m0_error} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_drop: got %b expected 000", {bus_read_enable, m0_done, m0_error});
    end
    @(negedge clock);
    reset = 0;
    bus_ready = 1;
    #1;
    checks++;
    if ({bus_read_enable, m0_done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_idle: got %b expected 00", {bus_read_enable, m0_done});
    end
    @(negedge clock);
    #1;
    checks++;
    if ({bus_read_enable, m0_done, m0_read_data} !== {1'b1, 1'b1, 32'h5A5A1234}) begin
      errors++;
      $display("FAIL reset_mid_regrant: got re=%b done=%b rd=%h expected 1 1 5a5a1234",
               bus_read_enable, m0_done, m0_read_data);
    end
    m0_req = 0;
  endtask

  // Transaction-level reference: who owns the bus, what was captured at grant,
  // and how many cycles the owner has been waiting.
  task automatic test_random();
    int          owner;
    int          last;
    int          elapsed;
    int          thr;
    logic [31:0] c_addr, c_wd;
    logic [3:0]  c_be;
    logic        c_we;
    logic [169:0] got, exp;
    logic        e_done0, e_done1, e_err0, e_err1, finished;
    logic [31:0] e_rd0, e_rd1;
    do_reset();
    owner = -1; last = 1; elapsed = 0;
    c_addr = 0; c_wd = 0; c_be = 0; c_we = 0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      @(negedge clock);
      case ((cyc / 60) % 3)
        0: thr = 0;
        1: thr = 4;
        default: thr = 9;
      endcase
      m0_req = ($urandom_range(0, 9) < 6); m1_req = ($urandom_range(0, 9) < 6);
      m0_address = $urandom; m1_address = $urandom;
      m0_write_data = $urandom; m1_write_data = $urandom;
      m0_byte_enable = 4'($urandom); m1_byte_enable = 4'($urandom);
      m0_write_enable = 1'($urandom); m1_write_enable = 1'($urandom);
      bus_read_data = $urandom;
      bus_ready = ($urandom_range(0, 9) < thr);
      #1;
      e_done0 = 0; e_done1 = 0; e_err0 = 0; e_err1 = 0; e_rd0 = 0; e_rd1 = 0;
      finished = 0;
      if (owner >= 0) begin
        if (bus_ready) begin
          finished = 1;
          if (owner == 0) begin e_done0 = 1; e_rd0 = bus_read_data; end
          else begin e_done1 = 1; e_rd1 = bus_read_data; end
        end else if (elapsed == TIMEOUT + 1) begin
          finished = 1;
          if (owner == 0) begin e_done0 = 1; e_err0 = 1; end
          else begin e_done1 = 1; e_err1 = 1; end
        end
        exp = {c_addr, c_wd, c_be, ~c_we, c_we, e_done0, e_done1, e_err0, e_err1, e_rd0, e_rd1};
      end else begin
        exp = {32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0};
      end
      got = {bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable,
             m0_done, m1_done, m0_error, m1_error, m0_read_data, m1_read_data};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random[%0d] owner=%0d: got %h expected %h", cyc, owner, got, exp);
      end
      @(posedge clock);
      if (owner < 0) begin
        if (m0_req && m1_req) owner = (last == 0) ? 1 : 0;
        else if (m0_req) owner = 0;
        else if (m1_req) owner = 1;
        if (owner == 0) begin
          c_addr = m0_address; c_wd = m0_write_data; c_be = m0_byte_enable; c_we = m0_write_enable;
        end else if (owner == 1) begin
          c_addr = m1_address; c_wd = m1_write_data; c_be = m1_byte_enable; c_we = m1_write_enable;
        end
        elapsed = 1;
      end else if (finished) begin
        last = owner;
        owner = -1;
      end else begin
        elapsed++;
      end
    end
    drive_idle();
  endtask

  initial begin
    reset = 1;
    drive_idle();
    test_reset();
    test_single_read();
    test_alternate();
    test_write_hold();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_bus_arbiter.md
MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning max cycles a granted transaction waits for bus_ready before abort (range 1..255).
REQ-002 SHALL have ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- m0_req, m1_req  in  1  requester 0 (data port) / requester 1 (fetch/DMA) transaction request, held until done
- m0_address, m1_address  in  32  byte address
- m0_write_data, m1_write_data  in  32  store data
- m0_byte_enable, m1_byte_enable  in  4  byte lanes
- m0_write_enable, m1_write_enable  in  1  1=write, 0=read
- m0_done, m1_done  out  1  one-cycle completion pulse
- m0_error, m1_error  out  1  one-cycle timeout pulse (with done)
- m0_read_data, m1_read_data  out  32  read result, valid with done
- bus_address  out  32; bus_write_data  out  32; bus_byte_enable  out  4
- bus_read_enable, bus_write_enable  out  1
- bus_read_data  in  32; bus_ready  in  1  slave completion

Function
REQ-003 SHALL implement FSM states IDLE, GRANT0, GRANT1.
REQ-004 In IDLE with exactly one req high, SHALL move to that requester's GRANT state at next edge.
REQ-005 In IDLE with both req high, SHALL grant requester not granted last (last_grant register); reset value of last_grant is 1, so m0 wins first tie.
REQ-006 On entering GRANTi, SHALL register mi address, write_data, byte_enable, write_enable; bus outputs driven only from these registers, so requester signal changes during grant have no effect.
REQ-007 In GRANTi, SHALL assert bus_write_enable if latched write_enable=1, else bus_read_enable; never both; both 0 in IDLE.
REQ-008 In GRANTi, cycle with bus_ready=1: mi_done=1 same cycle (combinational), mi_read_data=bus_read_data same cycle, FSM to IDLE, last_grant=i.
REQ-009 Minimum latency: req high at edge N (IDLE) -> bus enables high cycle N+1 -> done in cycle N+1 if bus_ready already 1.
REQ-010 Wait counter (8 bit) SHALL clear on grant entry, increment each GRANT cycle with bus_ready=0.
REQ-011 When counter equals TIMEOUT and bus_ready=0, SHALL pulse mi_done=1 and mi_error=1, mi_read_data=0, return to IDLE, set last_grant=i.
REQ-012 bus_ready outside GRANT states SHALL be ignored.
REQ-013 Deassertion of mi_req during GRANTi SHALL NOT abort; transaction completes, done still pulsed.
REQ-014 After a completion, a requester still holding req SHALL be re-arbitrated from IDLE (one idle cycle between back-to-back transactions).
REQ-015 m(non-granted)_done, _error SHALL be 0; its read_data SHALL be 0.
REQ-016 Two requesters both continuously requesting SHALL alternate grants strictly.

Reset
REQ-017 reset=1 SHALL asynchronously force: state IDLE, last_grant=1, counter 0, latched request registers 0, all bus_* outputs 0, all m*_done/error/read_data 0.
REQ-018 Reset asserted mid-transaction SHALL drop bus enables in same cycle without done pulse; after release, held req re-arbitrated from IDLE.

Verification
REQ-019 m0 read alone, address 0x100, bus_ready=1 first grant cycle, bus_read_data 0xDEADBEEF -> bus_read_enable high one cycle, m0_done pulse with m0_read_data 0xDEADBEEF, m1_done 0.
REQ-020 m0 and m1 req same edge after reset, bus_ready tied 1 -> order m0, m1, m0, m1; each grant separated by one IDLE cycle.
REQ-021 m1 write 0x12345678 to 0x200, byte_enable 0b0011, bus_ready delayed 3 cycles; m1_address changed to 0x300 mid-wait -> bus_address stays 0x200, bus_write_enable held 4 cycles, m1_done on 4th.
REQ-022 bus_ready held 0, TIMEOUT=15 -> m0_done and m0_error pulse on 16th grant cycle, m0_read_data 0, FSM IDLE next.
REQ-023 reset asserted in second wait cycle of m0 read -> bus_read_enable 0 immediately, no m0_done; after release with m0_req high, new grant starts next edge.
